// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : rename_free_list
// Brief    : Circular physical-register free list; hands out up to 4 prds per
//            cycle to dispatch and takes back up to 4 committed prds per cycle.
// Revision : 1.0
// ============================================================================
module rename_free_list #(
  parameter int WIDTH_REG = 7,
  parameter int NARCH     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [3:0]             i_alloc_req,
  input  logic                   i_alloc_en,
  output logic [4*WIDTH_REG-1:0] o_alloc_prd4x,
  output logic                   o_alloc_rdy,
  input  logic [4*WIDTH_REG-1:0] i_com_prd4x,
  input  logic                   i_com_en,
  output logic [WIDTH_REG:0]     o_free_cnt,
  output logic                   o_err
);

  localparam int c_nreg  = 2**WIDTH_REG;
  localparam int c_nlane = 4;
  localparam int c_ninit = c_nreg - NARCH;
  localparam logic [WIDTH_REG+1:0] c_cnt_max = (WIDTH_REG+2)'(c_nreg - 1);

  function automatic logic [2:0] f_popcnt(input logic [3:0] v);
    f_popcnt = {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  logic [WIDTH_REG-1:0] r_fifo [c_nreg];
  logic [WIDTH_REG-1:0] r_head;
  logic [WIDTH_REG-1:0] r_tail;
  logic [WIDTH_REG:0]   r_count;
  logic                 r_err;

  logic [c_nlane-1:0]      w_fvalid;
  logic [c_nlane-1:0][2:0] w_aoff;
  logic [c_nlane-1:0][2:0] w_foff;
  logic [2:0]              w_nalloc;
  logic [2:0]              w_nfree;
  logic [2:0]              w_ndec;
  logic                    w_fire;
  logic [WIDTH_REG+1:0]    w_cnt_inc;
  logic [WIDTH_REG+1:0]    w_cnt_next;
  logic                    w_ovf;
  logic                    w_unf;

  // Each lane's slot is offset by the number of active lanes below it.
  for (genvar i = 0; i < c_nlane; i++) begin : g_lane
    localparam logic [3:0] c_below = 4'((1 << i) - 1);
    logic [WIDTH_REG-1:0] w_com_prd;

    assign w_com_prd    = i_com_prd4x[i*WIDTH_REG +: WIDTH_REG];
    assign w_fvalid[i]  = i_com_en & (|w_com_prd);
    assign w_aoff[i]    = f_popcnt(i_alloc_req & c_below);
    assign w_foff[i]    = f_popcnt(w_fvalid & c_below);
    assign o_alloc_prd4x[i*WIDTH_REG +: WIDTH_REG] =
      i_alloc_req[i] ? r_fifo[r_head + WIDTH_REG'(w_aoff[i])] : '0;
  end

  assign w_nalloc    = f_popcnt(i_alloc_req);
  assign w_nfree     = f_popcnt(w_fvalid);
  assign o_alloc_rdy = (r_count >= (WIDTH_REG+1)'(4)) & ~i_rst;
  assign w_fire      = i_alloc_en & o_alloc_rdy;
  assign w_ndec      = w_fire ? w_nalloc : 3'd0;

  assign w_cnt_inc  = {1'b0, r_count} + (WIDTH_REG+2)'(w_nfree);
  assign w_cnt_next = w_cnt_inc - (WIDTH_REG+2)'(w_ndec);
  assign w_ovf      = w_cnt_inc > (c_cnt_max + (WIDTH_REG+2)'(w_ndec));
  assign w_unf      = w_cnt_inc < (WIDTH_REG+2)'(w_ndec);

  assign o_free_cnt = r_count;
  assign o_err      = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < c_nreg; k++) begin
        r_fifo[k] <= (k < c_ninit) ? WIDTH_REG'(NARCH + k) : '0;
      end
      r_head  <= '0;
      r_tail  <= WIDTH_REG'(c_ninit);
      r_count <= (WIDTH_REG+1)'(c_ninit);
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < c_nlane; i++) begin
        if (w_fvalid[i]) begin
          r_fifo[r_tail + WIDTH_REG'(w_foff[i])] <= i_com_prd4x[i*WIDTH_REG +: WIDTH_REG];
        end
      end
      if (w_fire) begin
        r_head <= r_head + WIDTH_REG'(w_nalloc);
      end
      r_tail <= r_tail + WIDTH_REG'(w_nfree);
      // Overflow still pushes; the count just pins at its maximum.
      if (w_ovf) begin
        r_count <= (WIDTH_REG+1)'(c_cnt_max);
      end else if (w_unf) begin
        r_count <= '0;
      end else begin
        r_count <= (WIDTH_REG+1)'(w_cnt_next);
      end
      r_err <= r_err | w_ovf | w_unf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list.sv
`default_nettype none
// Testbench for rename_free_list: vector table, directed corner sequences and
// randomized traffic against a queue-based free-list model.
module tb_rename_free_list;

  localparam int W = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     alloc_req = '0;
  logic           alloc_en = 1'b0;
  logic [4*W-1:0] alloc_prd4x;
  logic           alloc_rdy;
  logic [4*W-1:0] com_prd4x = '0;
  logic           com_en = 1'b0;
  logic [W:0]     free_cnt;
  logic           err;

  rename_free_list #(.WIDTH_REG(W), .NARCH(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_alloc_req   (alloc_req),
    .i_alloc_en    (alloc_en),
    .o_alloc_prd4x (alloc_prd4x),
    .o_alloc_rdy   (alloc_rdy),
    .i_com_prd4x   (com_prd4x),
    .i_com_en      (com_en),
    .o_free_cnt    (free_cnt),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: q is the ordered list of free registers, outst the ones handed out.
  int q[$];
  int outst[$];
  bit m_err;

  function automatic void m_reset();
    q.delete();
    outst.delete();
    for (int k = 32; k < 128; k++) q.push_back(k);
    m_err = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive, compare against the model away from the edge, then
  // advance the model at the edge.
  task automatic step(input bit r, input logic [3:0] req, input bit en,
                      input logic [4*W-1:0] cprd, input bit cen,
                      output logic [4*W-1:0] prd_seen, output logic [W:0] cnt_seen,
                      output logic rdy_seen);
    bit exp_rdy;
    int off;
    int e;
    int exp_cnt;
    rst = r; alloc_req = req; alloc_en = en; com_prd4x = cprd; com_en = cen;
    @(negedge clk);
    prd_seen = alloc_prd4x; cnt_seen = free_cnt; rdy_seen = alloc_rdy;
    exp_rdy = (q.size() >= 4) && !r;
    exp_cnt = (q.size() > 127) ? 127 : q.size();
    chk("alloc_rdy", {31'b0, alloc_rdy}, {31'b0, exp_rdy});
    chk("free_cnt", {24'b0, free_cnt}, exp_cnt);
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (exp_rdy) begin
      off = 0;
      for (int i = 0; i < 4; i++) begin
        e = 0;
        if (req[i]) begin e = q[off]; off++; end
        chk($sformatf("prd_lane%0d", i), {25'b0, alloc_prd4x[i*W +: W]}, e);
      end
    end
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      if (en && exp_rdy)
        for (int i = 0; i < 4; i++) if (req[i]) outst.push_back(q.pop_front());
      if (cen)
        for (int i = 0; i < 4; i++) if (cprd[i*W +: W] != 0) q.push_back(int'(cprd[i*W +: W]));
      if (q.size() > 127) m_err = 1'b1;
    end
    #1;
  endtask

  typedef struct {
    logic [3:0]     req;
    bit             en;
    logic [4*W-1:0] cprd;
    bit             cen;
    logic [4*W-1:0] exp_prd;
    int             exp_cnt;
  } vec_t;

  vec_t tbl[9];

  logic [4*W-1:0] ps;
  logic [W:0]     cs;
  logic           rs;
  logic [3:0]     rq;
  bit             ren;
  bit             rcen;
  logic [4*W-1:0] rc;
  int             j;

  initial begin
    tbl[0] = '{4'b1111, 1, '0, 0, {7'd35, 7'd34, 7'd33, 7'd32}, 96};
    tbl[1] = '{4'b1111, 1, '0, 0, {7'd39, 7'd38, 7'd37, 7'd36}, 92};
    tbl[2] = '{4'b1010, 1, '0, 0, {7'd41, 7'd0, 7'd40, 7'd0}, 88};
    tbl[3] = '{4'b0000, 1, '0, 0, '0, 86};
    tbl[4] = '{4'b0001, 0, {7'd0, 7'd0, 7'd0, 7'd5}, 1, {7'd0, 7'd0, 7'd0, 7'd42}, 86};
    tbl[5] = '{4'b0001, 1, '0, 0, {7'd0, 7'd0, 7'd0, 7'd42}, 87};
    tbl[6] = '{4'b0100, 1, '0, 0, {7'd0, 7'd43, 7'd0, 7'd0}, 86};
    tbl[7] = '{4'b1111, 1, {7'd0, 7'd0, 7'd9, 7'd0}, 1, {7'd47, 7'd46, 7'd45, 7'd44}, 85};
    tbl[8] = '{4'b0000, 0, '0, 0, '0, 82};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    step(1, 4'b0, 0, '0, 0, ps, cs, rs);
    chk("reset_rdy_low", {31'b0, rs}, 0);
    chk("reset_cnt", {24'b0, cs}, 96);

    // Vector table straight out of reset
    for (int t = 0; t < 9; t++) begin
      step(0, tbl[t].req, tbl[t].en, tbl[t].cprd, tbl[t].cen, ps, cs, rs);
      chk($sformatf("tbl%0d_prd", t), ps, tbl[t].exp_prd);
      chk($sformatf("tbl%0d_cnt", t), {24'b0, cs}, tbl[t].exp_cnt);
    end

    // Sparse request compaction
    step(1, 4'b0, 0, '0, 0, ps, cs, rs);
    step(0, 4'b1010, 1, '0, 0, ps, cs, rs);
    chk("sparse_prd", ps, {7'd33, 7'd0, 7'd32, 7'd0});
    step(0, 4'b0, 0, '0, 0, ps, cs, rs);
    chk("sparse_cnt", {24'b0, cs}, 94);

    // Drain to 3, then alloc is refused while two frees land
    step(1, 4'b0, 0, '0, 0, ps, cs, rs);
    repeat (23) step(0, 4'b1111, 1, '0, 0, ps, cs, rs);
    step(0, 4'b0001, 1, '0, 0, ps, cs, rs);
    step(0, 4'b1111, 1, {7'd0, 7'd40, 7'd0, 7'd41}, 1, ps, cs, rs);
    chk("low_cnt3", {24'b0, cs}, 3);
    chk("low_rdy0", {31'b0, rs}, 0);
    step(0, 4'b1111, 1, '0, 0, ps, cs, rs);
    chk("low_cnt5", {24'b0, cs}, 5);
    chk("low_rdy1", {31'b0, rs}, 1);
    chk("low_order", ps, {7'd41, 7'd127, 7'd126, 7'd125});

    // Simultaneous alloc 4 / free 4 at full count
    step(1, 4'b0, 0, '0, 0, ps, cs, rs);
    step(0, 4'b1111, 1, {7'd4, 7'd3, 7'd2, 7'd1}, 1, ps, cs, rs);
    step(0, 4'b0000, 0, '0, 0, ps, cs, rs);
    chk("same_cnt", {24'b0, cs}, 96);
    repeat (23) step(0, 4'b1111, 1, '0, 0, ps, cs, rs);
    step(0, 4'b1111, 1, '0, 0, ps, cs, rs);
    chk("same_order", ps, {7'd4, 7'd3, 7'd2, 7'd1});

    // Randomized traffic; frees drawn from outstanding registers only
    step(1, 4'b0, 0, '0, 0, ps, cs, rs);
    repeat (600) begin
      rq   = 4'($urandom);
      ren  = ($urandom_range(0, 3) != 0);
      rcen = ($urandom_range(0, 3) != 0);
      rc   = '0;
      if (rcen) begin
        for (int i = 0; i < 4; i++) begin
          if (outst.size() > 0 && $urandom_range(0, 3) != 0) begin
            j = $urandom_range(0, outst.size() - 1);
            rc[i*W +: W] = W'(outst[j]);
            outst.delete(j);
          end
        end
      end
      step(0, rq, ren, rc, rcen, ps, cs, rs);
    end

    // Overflow: 36 frees with no allocation
    step(1, 4'b0, 0, '0, 0, ps, cs, rs);
    for (int b = 0; b < 9; b++)
      step(0, 4'b0, 0, {7'(4*b+4), 7'(4*b+3), 7'(4*b+2), 7'(4*b+1)}, 1, ps, cs, rs);
    step(0, 4'b0, 0, '0, 0, ps, cs, rs);
    chk("ovf_cnt", {24'b0, cs}, 127);
    chk("ovf_err", {31'b0, err}, 1);
    step(0, 4'b0, 0, '0, 0, ps, cs, rs);
    chk("ovf_err_sticky", {31'b0, err}, 1);
    step(1, 4'b1111, 1, {7'd5, 7'd6, 7'd7, 7'd8}, 1, ps, cs, rs);
    chk("rst_rdy_low", {31'b0, rs}, 0);
    step(0, 4'b0, 0, '0, 0, ps, cs, rs);
    chk("rst_err_clr", {31'b0, err}, 0);
    chk("rst_cnt", {24'b0, cs}, 96);
    chk("rst_rdy_high", {31'b0, rs}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
